// File: rtl/encrypt_pipe.sv
`timescale 1ns/1ps
// encrypt_pipe: handshaked iterative encrypt path.
// A work unit is pre-mixed on accept, then run through ROUNDS rounds of
// nibble S-box substitution, full-state left-rotate and round-constant XOR,
// one round per clock, and presented on the output until consumed.
//
// Handshake: a unit moves on a rising edge where valid & ready are both high.
// in_valid/in_data must hold until accepted; out_valid/out_data hold until
// out_ready is seen high on an edge. in_ready is combinational so a finished
// unit can be consumed and a new one accepted on the same edge.
module encrypt_pipe #(
  parameter int WORD_BITS = 32,
  parameter int WORDS     = 8,
  parameter int ROUNDS    = 16,
  parameter int ROT_BITS  = 0,
  localparam int RW       = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [WORD_BITS*WORDS-1:0]   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WORD_BITS*WORDS-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic [RW-1:0]                round_idx
);

  localparam int DB  = WORD_BITS * WORDS;
  localparam int NIB = DB / 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [DB-1:0]   r_st;
  logic [DB-1:0]   r_out;
  logic [RW-1:0]   r_rnd;
  logic            r_out_valid;

  logic [WORD_BITS-1:0] w_total;
  logic [DB-1:0]        w_premix;
  logic [DB-1:0]        w_sub;
  logic [DB-1:0]        w_rot;
  logic [DB-1:0]        w_round;
  logic                 w_last;
  logic                 w_accept;

  // 4-bit substitution box applied to every nibble of the state
  function automatic logic [3:0] f_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Pre-mix: fold all words into one, then XOR the fold back into every word
  always_comb begin
    w_total  = '0;
    w_premix = in_data;
    for (int i = 0; i < WORDS; i++) begin
      w_total = w_total ^ in_data[i*WORD_BITS +: WORD_BITS];
    end
    for (int i = 0; i < WORDS; i++) begin
      w_premix[i*WORD_BITS +: WORD_BITS] = in_data[i*WORD_BITS +: WORD_BITS] ^ w_total;
    end
  end

  // Substitution layer of the current round
  always_comb begin
    w_sub = r_st;
    for (int n = 0; n < NIB; n++) begin
      w_sub[n*4 +: 4] = f_sbox(r_st[n*4 +: 4]);
    end
  end

  // Full-state left rotate; a zero rotate is a plain pass-through
  generate
    if (ROT_BITS == 0) begin : g_no_rot
      assign w_rot = w_sub;
    end else begin : g_rot
      assign w_rot = (w_sub << ROT_BITS) | (w_sub >> (DB - ROT_BITS));
    end
  endgenerate

  // Round constant is the round number itself, dropped into the low bits
  assign w_round  = w_rot ^ {{(DB-RW){1'b0}}, r_rnd};
  assign w_last   = (r_rnd == RW'(ROUNDS - 1));

  assign in_ready = ~flush & rst_n &
                    ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
  assign w_accept = in_valid & in_ready;

  assign out_data  = r_out;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != S_IDLE);
  assign round_idx = r_rnd;

  // Control FSM: IDLE -> RUN (ROUNDS edges) -> DONE -> IDLE or straight back to RUN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_st        <= '0;
      r_out       <= '0;
      r_rnd       <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      // Abort: the in-flight unit is dropped, the last result stays on out_data
      r_state     <= S_IDLE;
      r_rnd       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_st    <= w_premix;
            r_rnd   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_st <= w_round;
          if (w_last) begin
            r_out       <= w_round;
            r_out_valid <= 1'b1;
            r_rnd       <= '0;
            r_state     <= S_DONE;
          end else begin
            r_rnd <= r_rnd + RW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
              r_st    <= w_premix;
              r_rnd   <= '0;
              r_state <= S_RUN;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rnd       <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encrypt_pipe.sv
`timescale 1ns/1ps
// tb_encrypt_pipe: five encrypt_pipe instances with different round counts
// and rotates, checked against a plain-arithmetic reference model.
module tb_encrypt_pipe;

  localparam int NI = 5;
  localparam int K_ROUNDS [NI] = '{2, 1, 4, 16, 1};
  localparam int K_ROT    [NI] = '{0, 0, 0, 0, 4};
  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  // ---------------- clock / reset / signals ----------------
  logic clk;
  logic rst_n;
  logic [NI-1:0] flush;
  logic [NI-1:0] in_valid;
  logic [NI-1:0] out_ready;
  logic [255:0]  in_data [NI];
  wire  [NI-1:0] in_ready;
  wire  [NI-1:0] out_valid;
  wire  [NI-1:0] busy;
  wire  [255:0]  out_data [NI];
  wire  [0:0]    ri0;
  wire  [0:0]    ri1;
  wire  [1:0]    ri2;
  wire  [3:0]    ri3;
  wire  [0:0]    ri4;

  int n_tests = 0;
  int n_fail  = 0;
  logic [255:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  encrypt_pipe #(.WORD_BITS(32), .WORDS(8), .ROUNDS(2), .ROT_BITS(0)) u_r2 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .busy(busy[0]), .round_idx(ri0));
  encrypt_pipe #(.WORD_BITS(32), .WORDS(8), .ROUNDS(1), .ROT_BITS(0)) u_r1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .busy(busy[1]), .round_idx(ri1));
  encrypt_pipe #(.WORD_BITS(32), .WORDS(8), .ROUNDS(4), .ROT_BITS(0)) u_r4 (
    .clk(clk), .rst_n(rst_n), .flush(flush[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out_data(out_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .busy(busy[2]), .round_idx(ri2));
  encrypt_pipe #(.WORD_BITS(32), .WORDS(8), .ROUNDS(16), .ROT_BITS(0)) u_r16 (
    .clk(clk), .rst_n(rst_n), .flush(flush[3]), .in_data(in_data[3]), .in_valid(in_valid[3]),
    .in_ready(in_ready[3]), .out_data(out_data[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .busy(busy[3]), .round_idx(ri3));
  encrypt_pipe #(.WORD_BITS(32), .WORDS(8), .ROUNDS(1), .ROT_BITS(4)) u_rot (
    .clk(clk), .rst_n(rst_n), .flush(flush[4]), .in_data(in_data[4]), .in_valid(in_valid[4]),
    .in_ready(in_ready[4]), .out_data(out_data[4]), .out_valid(out_valid[4]),
    .out_ready(out_ready[4]), .busy(busy[4]), .round_idx(ri4));

  // ---------------- reference model ----------------
  function automatic logic [255:0] m_premix(input logic [255:0] d);
    logic [31:0]  t;
    logic [255:0] r;
    t = '0;
    for (int i = 0; i < 8; i++) t = t ^ d[i*32 +: 32];
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = d[i*32 +: 32] ^ t;
    return r;
  endfunction

  function automatic logic [255:0] m_encrypt(input logic [255:0] d, input int rounds, input int rot);
    logic [255:0] s;
    logic [255:0] x;
    s = m_premix(d);
    for (int r = 0; r < rounds; r++) begin
      for (int n = 0; n < 64; n++) x[n*4 +: 4] = SBOX[s[n*4 +: 4]];
      s = ((x << rot) | (x >> (256 - rot))) ^ 256'(r);
    end
    return s;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [3:0] ri(input int k);
    case (k)
      0: return {3'b0, ri0};
      1: return {3'b0, ri1};
      2: return {2'b0, ri2};
      3: return ri3;
      default: return {3'b0, ri4};
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present a unit and hold it until accepted; returns at the negedge after the accept edge
  task automatic send(input int k, input logic [255:0] d);
    int n;
    n = 0;
    in_data[k]  = d;
    in_valid[k] = 1'b1;
    #1;
    while (!in_ready[k] && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready[k]) chk("send_timeout", 256'(in_ready[k]), 256'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  // Count edges until out_valid; lat is measured from the accept edge inclusive
  task automatic wait_valid(input int k, output int lat);
    int n;
    n = 0;
    while (!out_valid[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid[k]) chk("valid_timeout", 256'(out_valid[k]), 256'(1));
    lat = n + 1;
  endtask

  // Random stream with random source gaps and sink stalls, scoreboarded in order
  task automatic stream(input int k, input int n_units);
    int  sent, got, cyc;
    bit  pend;
    logic [255:0] e;
    sent = 0; got = 0; cyc = 0; pend = 0;
    exp_q.delete();
    in_valid[k] = 1'b0;
    while (got < n_units && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        in_valid[k] = 1'b0;
        pend = 0;
      end
      out_ready[k] = ($urandom_range(0, 3) != 0);
      if (!in_valid[k] && sent < n_units && $urandom_range(0, 2) != 0) begin
        in_data[k]  = rand256();
        in_valid[k] = 1'b1;
      end
      #1;
      if (out_valid[k] && out_ready[k]) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 256'(1), 256'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", out_data[k], e);
        end
        got++;
      end
      if (in_valid[k] && in_ready[k]) begin
        exp_q.push_back(m_encrypt(in_data[k], K_ROUNDS[k], K_ROT[k]));
        sent++;
        pend = 1;
      end
    end
    @(negedge clk);
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    chk("sb_count", 256'(got), 256'(n_units));
    chk("sb_left", 256'(exp_q.size()), 256'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int seen;
    logic [255:0] d0, d1;

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      flush[k]     = 1'b0;
      in_valid[k]  = 1'b1;
      out_ready[k] = 1'b0;
      in_data[k]   = rand256();
    end

    // Reset with in_valid high: everything reads zero
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_out_data",  out_data[k], '0);
      chk("rst_out_valid", 256'(out_valid[k]), 256'(0));
      chk("rst_busy",      256'(busy[k]), 256'(0));
      chk("rst_round_idx", 256'(ri(k)), 256'(0));
      chk("rst_in_ready",  256'(in_ready[k]), 256'(0));
    end
    rst_n    = 1'b1;
    in_valid = '0;
    #1;
    for (int k = 0; k < NI; k++) chk("rel_in_ready", 256'(in_ready[k]), 256'(1));
    out_ready = '1;
    @(negedge clk);

    // ROUNDS=2, all-zero unit
    send(0, '0);
    chk("r2_run_idx",  256'(ri(0)), 256'(0));
    chk("r2_run_busy", 256'(busy[0]), 256'(1));
    wait_valid(0, lat);
    chk("r2_latency", 256'(lat), 256'(K_ROUNDS[0] + 1));
    chk("r2_data_const", out_data[0], {{63{4'h4}}, 4'h5});
    chk("r2_data_model", out_data[0], m_encrypt('0, 2, 0));
    @(negedge clk);
    chk("r2_after_valid", 256'(out_valid[0]), 256'(0));
    chk("r2_after_busy",  256'(busy[0]), 256'(0));
    chk("r2_hold_data",   out_data[0], {{63{4'h4}}, 4'h5});

    // ROUNDS=1, word0=1
    send(1, 256'h1);
    chk("r1_run_idx", 256'(ri(1)), 256'(0));
    wait_valid(1, lat);
    chk("r1_latency", 256'(lat), 256'(2));
    chk("r1_data", out_data[1], {{7{32'hCCCCCCC5}}, 32'hCCCCCCCC});
    @(negedge clk);

    // ROUNDS=4: sink stall, then back-to-back accept on the release edge
    out_ready[2] = 1'b0;
    d0 = rand256();
    send(2, d0);
    wait_valid(2, lat);
    chk("r4_latency", 256'(lat), 256'(5));
    for (int i = 0; i < 10; i++) begin
      chk("r4_stall_data",  out_data[2], m_encrypt(d0, 4, 0));
      chk("r4_stall_ready", 256'(in_ready[2]), 256'(0));
      chk("r4_stall_valid", 256'(out_valid[2]), 256'(1));
      @(negedge clk);
    end
    d1 = rand256();
    in_data[2]   = d1;
    in_valid[2]  = 1'b1;
    out_ready[2] = 1'b1;
    #1;
    chk("r4_b2b_ready", 256'(in_ready[2]), 256'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid[2] = 1'b0;
    chk("r4_b2b_idx",   256'(ri(2)), 256'(0));
    chk("r4_b2b_busy",  256'(busy[2]), 256'(1));
    chk("r4_b2b_valid", 256'(out_valid[2]), 256'(0));
    wait_valid(2, lat);
    chk("r4_b2b_latency", 256'(lat), 256'(5));
    chk("r4_b2b_data", out_data[2], m_encrypt(d1, 4, 0));
    @(negedge clk);

    // ROUNDS=16: flush at round 2
    send(3, rand256());
    seen = 0;
    while (ri(3) != 4'd2 && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    chk("fl_reach_idx", 256'(ri(3)), 256'(2));
    flush[3] = 1'b1;
    #1;
    chk("fl_in_ready", 256'(in_ready[3]), 256'(0));
    @(posedge clk);
    @(negedge clk);
    flush[3] = 1'b0;
    chk("fl_busy",  256'(busy[3]), 256'(0));
    chk("fl_valid", 256'(out_valid[3]), 256'(0));
    chk("fl_idx",   256'(ri(3)), 256'(0));
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid[3]) seen = 1;
    end
    chk("fl_no_output", 256'(seen), 256'(0));
    // Flush in IDLE blocks the accept and changes nothing else
    flush[3]    = 1'b1;
    in_valid[3] = 1'b1;
    in_data[3]  = rand256();
    #1;
    chk("fl_idle_ready", 256'(in_ready[3]), 256'(0));
    @(posedge clk);
    @(negedge clk);
    flush[3]    = 1'b0;
    in_valid[3] = 1'b0;
    chk("fl_idle_busy", 256'(busy[3]), 256'(0));
    d0 = rand256();
    send(3, d0);
    wait_valid(3, lat);
    chk("fl_next_latency", 256'(lat), 256'(17));
    chk("fl_next_data", out_data[3], m_encrypt(d0, 16, 0));
    @(negedge clk);

    // ROT_BITS=4, ROUNDS=1: single unit, then a 100-unit random stream
    send(4, 256'h1);
    wait_valid(4, lat);
    chk("rot_data", out_data[4], m_encrypt(256'h1, 1, 4));
    @(negedge clk);
    stream(4, 100);

    // ROUNDS=4 random stream with stalls
    stream(2, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
